// File: rtl/oop_pkg.sv
// rtl/oop_pkg.sv - shared constants and entry layout for the reorder buffer
package oop_pkg;

    localparam int ROB_DEPTH  = 64;
    localparam int ROB_IDX_W  = 6;
    localparam int DATA_W     = 16;
    localparam int ARCH_REG_W = 3;
    localparam int DISPATCH_W = 4;
    localparam int CMP_W      = 3;
    localparam int COMMIT_W   = 3;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  has_dest;
        logic [ARCH_REG_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// rtl/rob_commit_sel.sv - counts leading valid+done entries in the retire window
module rob_commit_sel
    import oop_pkg::*;
(
    input  rob_entry_t [COMMIT_W-1:0] win_i,
    output logic       [COMMIT_W-1:0] lane_valid_o,
    output logic       [1:0]          k_o
);

    logic [COMMIT_W-1:0] ready;

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            ready[i] = win_i[i].valid && win_i[i].done;
        end
        // A lane may only retire if every older lane in the window retires too.
        lane_valid_o[0] = ready[0];
        lane_valid_o[1] = ready[0] && ready[1];
        lane_valid_o[2] = ready[0] && ready[1] && ready[2];
        k_o = {1'b0, lane_valid_o[0]} + {1'b0, lane_valid_o[1]} + {1'b0, lane_valid_o[2]};
    end

endmodule

// File: rtl/rob_core.sv
// rtl/rob_core.sv - 64-entry reorder buffer: 4-wide allocate, 3-wide complete, 3-wide in-order retire
module rob_core
    import oop_pkg::*;
#(
    parameter int DEPTH  = oop_pkg::ROB_DEPTH,
    parameter int IDX_W  = oop_pkg::ROB_IDX_W,
    parameter int DATA_W = oop_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DISPATCH_W-1:0]     alloc_valid,
    input  logic [DISPATCH_W-1:0]     alloc_has_dest,
    input  logic [4*ARCH_REG_W-1:0]   alloc_dest,
    output logic                      alloc_ready,
    output logic [4*IDX_W-1:0]        alloc_loc,
    input  logic [CMP_W-1:0]          cmp_valid,
    input  logic [CMP_W*IDX_W-1:0]    cmp_loc,
    input  logic [CMP_W*DATA_W-1:0]   cmp_data,
    input  logic                      flush,
    output logic [COMMIT_W-1:0]       commit_valid,
    output logic [COMMIT_W*IDX_W-1:0] commit_loc,
    output logic                      wen0,
    output logic                      wen1,
    output logic                      wen2,
    output logic [ARCH_REG_W-1:0]     waddr0,
    output logic [ARCH_REG_W-1:0]     waddr1,
    output logic [ARCH_REG_W-1:0]     waddr2,
    output logic [DATA_W-1:0]         wdata0,
    output logic [DATA_W-1:0]         wdata1,
    output logic [DATA_W-1:0]         wdata2,
    output logic [IDX_W:0]            count
);

    rob_entry_t                rob_q [DEPTH];
    logic [IDX_W-1:0]          head_q, head_d;
    logic [IDX_W-1:0]          tail_q, tail_d;
    logic [IDX_W:0]            count_q, count_d;
    logic [2:0]                n_alloc;
    logic [1:0]                k_commit;
    logic [COMMIT_W-1:0]       lane_valid;
    rob_entry_t [COMMIT_W-1:0] win;

    assign alloc_ready = (count_q <= (IDX_W+1)'(DEPTH - DISPATCH_W));
    assign count       = count_q;

    always_comb begin
        for (int i = 0; i < DISPATCH_W; i++) begin
            alloc_loc[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
        end
        for (int i = 0; i < COMMIT_W; i++) begin
            win[i]                       = rob_q[head_q + IDX_W'(i)];
            commit_loc[i*IDX_W +: IDX_W] = head_q + IDX_W'(i);
        end
    end

    rob_commit_sel u_commit_sel (
        .win_i        (win),
        .lane_valid_o (lane_valid),
        .k_o          (k_commit)
    );

    // Flush suppresses retirement combinationally so nothing reaches the register file.
    assign commit_valid = lane_valid & {COMMIT_W{~flush}};
    assign wen0   = commit_valid[0] && win[0].has_dest;
    assign wen1   = commit_valid[1] && win[1].has_dest;
    assign wen2   = commit_valid[2] && win[2].has_dest;
    assign waddr0 = win[0].dest;
    assign waddr1 = win[1].dest;
    assign waddr2 = win[2].dest;
    assign wdata0 = win[0].data;
    assign wdata1 = win[1].data;
    assign wdata2 = win[2].data;

    always_comb begin
        n_alloc = '0;
        if (alloc_ready) begin
            n_alloc = {2'b0, alloc_valid[0]} + {2'b0, alloc_valid[1]}
                    + {2'b0, alloc_valid[2]} + {2'b0, alloc_valid[3]};
        end
        head_d  = head_q + IDX_W'(k_commit);
        tail_d  = tail_q + IDX_W'(n_alloc);
        count_d = count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(k_commit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Later lanes overwrite earlier ones, so the highest lane wins a collision.
            for (int l = 0; l < CMP_W; l++) begin
                if (cmp_valid[l] && rob_q[cmp_loc[l*IDX_W +: IDX_W]].valid) begin
                    rob_q[cmp_loc[l*IDX_W +: IDX_W]].done <= 1'b1;
                    rob_q[cmp_loc[l*IDX_W +: IDX_W]].data <= cmp_data[l*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (lane_valid[i]) begin
                    rob_q[head_q + IDX_W'(i)] <= '0;
                end
            end
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (alloc_ready && alloc_valid[i]) begin
                    rob_q[tail_q + IDX_W'(i)] <= '{valid:    1'b1,
                                                   done:     1'b0,
                                                   has_dest: alloc_has_dest[i],
                                                   dest:     alloc_dest[i*ARCH_REG_W +: ARCH_REG_W],
                                                   data:     '0};
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_core.sv
// tb/tb_rob_core.sv - self-checking bench for rob_core with retirement scoreboard
module tb_rob_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  alloc_valid, alloc_has_dest;
    logic [11:0] alloc_dest;
    logic        alloc_ready;
    logic [23:0] alloc_loc;
    logic [2:0]  cmp_valid;
    logic [17:0] cmp_loc;
    logic [47:0] cmp_data;
    logic        flush;
    logic [2:0]  commit_valid;
    logic [17:0] commit_loc;
    logic        wen0, wen1, wen2;
    logic [2:0]  waddr0, waddr1, waddr2;
    logic [15:0] wdata0, wdata1, wdata2;
    logic [6:0]  count;

    always #5 clk = ~clk;

    rob_core dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_loc(alloc_loc),
        .cmp_valid(cmp_valid), .cmp_loc(cmp_loc), .cmp_data(cmp_data),
        .flush(flush), .commit_valid(commit_valid), .commit_loc(commit_loc),
        .wen0(wen0), .wen1(wen1), .wen2(wen2),
        .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .count(count)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [23:0] mkloc(input logic [5:0] b);
        return {b + 6'd3, b + 6'd2, b + 6'd1, b};
    endfunction

    typedef struct {
        logic [5:0]  loc;
        logic        has_dest;
        logic [2:0]  dest;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic push(input logic [5:0] loc, input logic hd, input logic [2:0] dest, input logic [15:0] data);
        exp_t e;
        e.loc = loc; e.has_dest = hd; e.dest = dest; e.data = data;
        sb.push_back(e);
    endtask

    logic [2:0]  wen_v;
    logic [2:0]  waddr_v [3];
    logic [15:0] wdata_v [3];
    assign wen_v      = {wen2, wen1, wen0};
    assign waddr_v[0] = waddr0;
    assign waddr_v[1] = waddr1;
    assign waddr_v[2] = waddr2;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;
    assign wdata_v[2] = wdata2;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            chk("wen_without_commit", wen_v & ~commit_valid, 3'b000);
            for (int i = 0; i < 3; i++) begin
                if (commit_valid[i]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: lane %0d loc %0d, scoreboard empty", i, commit_loc[i*6 +: 6]);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_commit_loc", commit_loc[i*6 +: 6], e.loc);
                        chk("sb_wen", wen_v[i], e.has_dest);
                        if (e.has_dest) begin
                            chk("sb_waddr", waddr_v[i], e.dest);
                            chk("sb_wdata", wdata_v[i], e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alloc_valid = '0; alloc_has_dest = '0; alloc_dest = '0;
        cmp_valid = '0; cmp_loc = '0; cmp_data = '0; flush = 1'b0;
    endtask

    task automatic cmp(input int lane, input logic [5:0] loc, input logic [15:0] d);
        cmp_valid[lane]         = 1'b1;
        cmp_loc[lane*6 +: 6]    = loc;
        cmp_data[lane*16 +: 16] = d;
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    typedef struct {
        logic [3:0] av;
        logic [6:0] exp_count;
        logic [5:0] exp_tail;
        logic       exp_ready;
    } vec_t;

    vec_t vt [6];

    initial begin
        vt[0] = '{av: 4'b0001, exp_count: 7'd1,  exp_tail: 6'd1,  exp_ready: 1'b1};
        vt[1] = '{av: 4'b0011, exp_count: 7'd3,  exp_tail: 6'd3,  exp_ready: 1'b1};
        vt[2] = '{av: 4'b0000, exp_count: 7'd3,  exp_tail: 6'd3,  exp_ready: 1'b1};
        vt[3] = '{av: 4'b0111, exp_count: 7'd6,  exp_tail: 6'd6,  exp_ready: 1'b1};
        vt[4] = '{av: 4'b1111, exp_count: 7'd10, exp_tail: 6'd10, exp_ready: 1'b1};
        vt[5] = '{av: 4'b1111, exp_count: 7'd14, exp_tail: 6'd14, exp_ready: 1'b1};

        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_count", count, 7'd0);
        chk("reset_ready", alloc_ready, 1'b1);
        chk("reset_alloc_loc", alloc_loc, mkloc(6'd0));
        chk("reset_commit_valid", commit_valid, 3'b000);
        chk("reset_wen", wen_v, 3'b000);

        for (int i = 0; i < 6; i++) begin
            alloc_valid = vt[i].av;
            tick();
            idle();
            chk("vec_count", count, vt[i].exp_count);
            chk("vec_alloc_loc", alloc_loc, mkloc(vt[i].exp_tail));
            chk("vec_ready", alloc_ready, vt[i].exp_ready);
            chk("vec_no_commit", commit_valid, 3'b000);
        end
        do_flush();
        chk("vec_flush_count", count, 7'd0);

        // Out-of-order completion
        alloc_valid = 4'hF; alloc_has_dest = 4'hF; alloc_dest = {3'd4, 3'd3, 3'd2, 3'd1};
        tick(); idle();
        chk("ooo_count4", count, 7'd4);
        cmp(0, 6'd2, 16'h0022);
        tick(); idle();
        chk("ooo_no_commit", commit_valid, 3'b000);
        cmp(0, 6'd0, 16'h0000);
        push(6'd0, 1'b1, 3'd1, 16'h0000);
        tick(); idle();
        chk("ooo_lane0_only", commit_valid, 3'b001);
        chk("ooo_wen_lane0", wen_v, 3'b001);
        chk("ooo_waddr0", waddr0, 3'd1);
        cmp(0, 6'd1, 16'h0011);
        push(6'd1, 1'b1, 3'd2, 16'h0011);
        push(6'd2, 1'b1, 3'd3, 16'h0022);
        tick(); idle();
        chk("ooo_commit2", commit_valid, 3'b011);
        chk("ooo_waddr0_r2", waddr0, 3'd2);
        chk("ooo_wdata0", wdata0, 16'h0011);
        chk("ooo_waddr1_r3", waddr1, 3'd3);
        chk("ooo_wdata1", wdata1, 16'h0022);
        tick();
        chk("ooo_count1", count, 7'd1);
        do_flush();

        // Fill and wrap
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 4'hF; alloc_has_dest = 4'hF; alloc_dest = {3'd7, 3'd6, 3'd5, 3'd4};
            tick();
        end
        idle();
        chk("fill_count64", count, 7'd64);
        chk("fill_not_ready", alloc_ready, 1'b0);
        cmp(0, 6'd0, 16'hA000); cmp(1, 6'd1, 16'hA001); cmp(2, 6'd2, 16'hA002);
        push(6'd0, 1'b1, 3'd4, 16'hA000);
        push(6'd1, 1'b1, 3'd5, 16'hA001);
        push(6'd2, 1'b1, 3'd6, 16'hA002);
        alloc_valid = 4'hF; alloc_has_dest = 4'hF;
        tick(); idle();
        chk("full_alloc_ignored", count, 7'd64);
        chk("full_commit3", commit_valid, 3'b111);
        cmp(0, 6'd3, 16'hA003);
        push(6'd3, 1'b1, 3'd7, 16'hA003);
        alloc_valid = 4'hF;
        tick(); idle();
        chk("wrap_count61", count, 7'd61);
        chk("wrap_ready_0", alloc_ready, 1'b0);
        tick();
        chk("wrap_count60", count, 7'd60);
        chk("wrap_ready_1", alloc_ready, 1'b1);
        chk("wrap_alloc_loc", alloc_loc, mkloc(6'd0));

        // Simultaneous commit and allocate at capacity
        alloc_valid = 4'b0011; alloc_has_dest = 4'b0011; alloc_dest = {3'd7, 3'd6, 3'd5, 3'd4};
        tick(); idle();
        chk("cap_count62", count, 7'd62);
        chk("cap_ready_0", alloc_ready, 1'b0);
        cmp(0, 6'd4, 16'hB004); cmp(1, 6'd5, 16'hB005);
        push(6'd4, 1'b1, 3'd4, 16'hB004);
        push(6'd5, 1'b1, 3'd5, 16'hB005);
        tick(); idle();
        alloc_valid = 4'hF; alloc_has_dest = 4'hF;
        chk("cap_ready_still_0", alloc_ready, 1'b0);
        chk("cap_commit2", commit_valid, 3'b011);
        tick(); idle();
        chk("cap_count60", count, 7'd60);
        chk("cap_ready_1", alloc_ready, 1'b1);
        chk("cap_alloc_loc", alloc_loc, mkloc(6'd2));
        do_flush();

        // No-destination entry, then a completion lane collision
        alloc_valid = 4'b0001; alloc_has_dest = 4'b0000; alloc_dest = 12'd5;
        tick(); idle();
        cmp(0, 6'd0, 16'h1234);
        push(6'd0, 1'b0, 3'd5, 16'h1234);
        tick(); idle();
        chk("nodest_commit", commit_valid, 3'b001);
        chk("nodest_wen", wen_v, 3'b000);
        tick();
        chk("nodest_count0", count, 7'd0);
        alloc_valid = 4'b0001; alloc_has_dest = 4'b0001; alloc_dest = 12'd2;
        tick(); idle();
        cmp(0, 6'd1, 16'h5555); cmp(2, 6'd1, 16'h6666);
        push(6'd1, 1'b1, 3'd2, 16'h6666);
        tick(); idle();
        chk("head_advanced_loc", commit_loc[5:0], 6'd1);
        chk("collision_high_lane", wdata0, 16'h6666);
        tick();
        do_flush();

        // Flush with three done entries at head
        alloc_valid = 4'hF; alloc_has_dest = 4'hF; alloc_dest = {3'd4, 3'd3, 3'd2, 3'd1};
        tick(); idle();
        cmp(0, 6'd0, 16'h0001); cmp(1, 6'd1, 16'h0002); cmp(2, 6'd2, 16'h0003);
        tick(); idle();
        flush = 1'b1;
        #1;
        chk("flush_commit_valid", commit_valid, 3'b000);
        chk("flush_wen", wen_v, 3'b000);
        tick();
        flush = 1'b0;
        chk("flush_count0", count, 7'd0);
        chk("flush_alloc_loc", alloc_loc, mkloc(6'd0));
        cmp(0, 6'd3, 16'h7777);
        tick(); idle();
        chk("late_cmp_ignored", commit_valid, 3'b000);
        chk("late_cmp_count", count, 7'd0);
        alloc_valid = 4'b0001; alloc_has_dest = 4'b0001;
        tick(); idle();
        chk("realloc_not_done", commit_valid, 3'b000);
        chk("realloc_count1", count, 7'd1);

        // Reset mid-operation
        alloc_valid = 4'b0011;
        tick(); idle();
        chk("pre_rst_count3", count, 7'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_count", count, 7'd0);
        chk("mid_rst_alloc_loc", alloc_loc, mkloc(6'd0));
        chk("mid_rst_commit", commit_valid, 3'b000);

        tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_core.md
Name: rob_core

Overview:
- 64-entry reorder buffer between rename/dispatch and the architectural register file.
- Hands out ROB locations to up to 4 dispatch slots per cycle (A..D). Dispatch writes these locations into the register file's rename tags.
- Captures up to 3 out-of-order results per cycle from functional units.
- Retires up to 3 completed entries per cycle, in program order, into the register file's 3 write ports.

Parameters:
- DEPTH, 64, number of entries (power of two).
- IDX_W, 6, log2(DEPTH), ROB location width.
- DATA_W, 16, result width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alloc_valid  in  4  slot requests, bit0=A..bit3=D; must be thermometer-coded (0000/0001/0011/0111/1111)
- alloc_has_dest  in  4  per slot: entry writes an architectural register
- alloc_dest  in  12  {D,C,B,A} 3-bit destination register numbers
- alloc_ready  out  1  1 when free entries >= 4
- alloc_loc  out  24  {D,C,B,A} 6-bit locations; slot i gets tail+i mod 64
- cmp_valid  in  3  completion lane valids
- cmp_loc  in  18  {2,1,0} 6-bit completing locations
- cmp_data  in  48  {2,1,0} 16-bit results
- flush  in  1  discard all entries
- commit_valid  out  3  lane i retires entry head+i
- commit_loc  out  18  {2,1,0} retiring locations
- wen0/wen1/wen2  out  1 each  register write enables
- waddr0/waddr1/waddr2  out  3 each  register numbers
- wdata0/wdata1/wdata2  out  16 each  write data
- count  out  7  occupied entries, 0..64

Behaviour:
- Entry state: valid, done, has_dest, dest[2:0], data[15:0]. Pointers: head, tail (6-bit, wrap mod 64), count.
- Reset (rst_n=0 at posedge): all valid/done cleared; head=tail=0; count=0.
  - Resulting outputs: alloc_ready=1, alloc_loc={3,2,1,0}, commit_valid=0, wen*=0.
- Allocation:
  - Accepted at a posedge only if alloc_ready=1. Requests while alloc_ready=0 are ignored; the upstream stage holds them.
  - n = popcount(alloc_valid). Entries tail..tail+n-1 set valid=1, done=0, with has_dest/dest latched.
  - tail += n.
  - alloc_ready and alloc_loc depend on registered state only. Entries freed by commit become usable the following cycle.
- Completion:
  - Lane k valid at a posedge sets done=1 and data=cmp_data_k on entry cmp_loc_k.
  - Ignored if that entry is not valid.
  - If two lanes hit the same loc, the higher lane wins.
- Commit (combinational from registered state):
  - k = number of consecutive valid and done entries starting at head, capped at 3.
  - commit_valid lane i = (i < k) && !flush; commit_loc_i = head+i.
  - wen_i = commit_valid_i && has_dest; waddr_i = dest; wdata_i = data.
  - Lane 0 is always the oldest, so the younger write wins in the register file when waddrs collide.
  - At posedge: committed entries are cleared and head += k.
  - A result completing at edge E is visible on the commit outputs in the cycle after E.
- Count: count_next = count + n_alloc - k_commit. Never exceeds 64. Never underflows.
- Simultaneous allocation and commit in one cycle are both applied.
- Flush: has priority over allocation, completion and commit in the same cycle.
  - wen*/commit_valid are forced to 0 combinationally while flush=1.
  - At the edge, state equals reset state.
- Reset asserted mid-operation behaves identically to flush.

Decomposition:
- Shared package oop_pkg holds:
  - constants ROB_DEPTH=64, ROB_IDX_W=6, DATA_W=16, ARCH_REG_W=3, DISPATCH_W=4, CMP_W=3, COMMIT_W=3;
  - the packed rob_entry_t struct.
- One natural sub-module: rob_commit_sel, a combinational leading-done counter over head..head+2 returning k and per-lane valids.

Test Plan:
- Reset -> count=0, alloc_ready=1, alloc_loc={3,2,1,0}, commit_valid=000, wen*=0.
- Out-of-order completion:
  - Stimulus: allocate 4 (dests r1..r4); complete loc2 (0x0022); next cycle complete loc0 (0x0000); then loc1 (0x0011).
  - Response: no commit after loc2 alone. After loc0: wen0=1 waddr0=1 only. After loc1: wen0/wen1 write r2=0x0011, r3=0x0022; count=1.
- Fill and wrap:
  - 16 cycles of 4-wide allocation -> count=64, alloc_ready=0.
  - Commit 3 -> count=61, alloc_ready still 0.
  - 1 more commit -> alloc_ready=1, alloc_loc={3,2,1,0} (wrapped).
- No-dest entry: allocate with has_dest=0, complete -> commit_valid lane0=1, wen0=0; head advances.
- Simultaneous at capacity: count=62, commit 2 while requesting 4 -> alloc ignored (ready=0 that cycle); next cycle count=60, ready=1.
- Flush with 3 done entries at head -> commit_valid=0, wen*=0 that cycle; next cycle count=0, alloc_loc={3,2,1,0}. A late completion to an old loc is ignored.
